// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;
    localparam int OFF_W   = 4;

    localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        ISSUE,
        RESOLVE,
        HALT
    } state_t;

    function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
        return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: branch target (signed offset) or sequential, wrapping mod 256.
module pc_next
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic             branch,
    input  logic [OFF_W-1:0] branch_off,
    output logic [PC_W-1:0]  next_pc
);

    always_comb begin
        next_pc = pc + (branch ? sext_off(branch_off) : PC_W'(1));
    end

endmodule

// File: rtl/fetch_unit.sv
// Non-speculative fetch FSM: one instruction in flight, fetch -> issue -> resolve.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               resolve_valid,
    input  logic               branch,
    input  logic [OFF_W-1:0]   branch_off,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    state_t          state, next_state;
    logic [PC_W-1:0] pc_n;

    pc_next u_pc_next (
        .pc         (pc),
        .branch     (branch),
        .branch_off (branch_off),
        .next_pc    (pc_n)
    );

    // FETCH entered from reset has imem_req low; it lingers one cycle to raise the strobe.
    always_comb begin
        next_state = state;
        case (state)
            FETCH:   if (imem_req) next_state = WAIT;
            WAIT:    if (imem_valid)
                         next_state = (imem_data == HALT_OPCODE) ? HALT : ISSUE;
            ISSUE:   if (instr_ready) next_state = RESOLVE;
            RESOLVE: if (resolve_valid) next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= '0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= next_state;
            imem_req    <= (next_state == FETCH);
            instr_valid <= (next_state == ISSUE);
            halted      <= (next_state == HALT);
            if (state == WAIT && imem_valid) begin
                instr <= imem_data;
            end
            if (state == RESOLVE && resolve_valid) begin
                pc        <= pc_n;
                imem_addr <= pc_n;
            end
        end
    end

endmodule
